seq_pattern_tx: RTL and testbench

Serial pattern transmitter that produces the bit stream consumed by the team's Mealy sequence detectors.
- Captures a W-bit pattern on a start request and shifts it out MSB-first, one bit per clock, on x.
- Optionally repeats the pattern a programmed number of times, with a programmable idle gap between repetitions.
- Used as the stimulus source in front of the detector's x input, and as a standalone serializer.

---
 rtl/seq_pattern_tx_if.sv | 28 ++
 rtl/seq_pattern_tx.sv | 123 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_pattern_tx_if.sv
// Request/stream interface of the serial pattern transmitter.
//   master : requester side that drives start/pattern/repeat_cnt/gap and observes the stream
//   slave  : transmitter side that samples the request and drives x/x_valid/busy/done
// The repeat count is carried on repeat_cnt because "repeat" is a reserved word.
interface seq_pattern_tx_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 3
) ();
  logic             start;
  logic [W-1:0]     pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic [GAP_W-1:0] gap;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt, gap,
    input  x, x_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt, gap,
    output x, x_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a W-bit pattern on start and shifts it out
// MSB-first on x, repeating it repeat_cnt times (0 acts as 1) with gap idle cycles
// between repetitions.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset
//   bus    : seq_pattern_tx_if.slave
//            start/pattern/repeat_cnt/gap in, x/x_valid/busy/done out (all registered)
module seq_pattern_tx #(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_tx_if.slave   bus
);

  localparam int unsigned IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     shreg;      // current bit is always at the MSB
  logic [W-1:0]     pat_q;      // captured pattern, used to reload on repeats
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] reps_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;

  // Single-process FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      pat_q       <= '0;
      bit_idx     <= '0;
      reps_left   <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      bus.x       <= 1'b0;
      bus.x_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            pat_q       <= bus.pattern;
            shreg       <= bus.pattern;
            reps_left   <= (bus.repeat_cnt == '0) ? CNT_W'(1) : bus.repeat_cnt;
            gap_q       <= bus.gap;
            bit_idx     <= LAST_IDX;
            bus.x       <= bus.pattern[W-1];
            bus.x_valid <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= SEND;
          end
        end

        SEND: begin
          if (bit_idx != '0) begin
            shreg   <= shreg << 1;
            bus.x   <= shreg[W-2];
            bit_idx <= bit_idx - IDX_W'(1);
          end else if (reps_left > CNT_W'(1)) begin
            reps_left <= reps_left - CNT_W'(1);
            shreg     <= pat_q;
            if (gap_q == '0) begin
              // Back-to-back repetition: next pattern's MSB follows immediately.
              bus.x       <= pat_q[W-1];
              bus.x_valid <= 1'b1;
              bit_idx     <= LAST_IDX;
            end else begin
              bus.x       <= 1'b0;
              bus.x_valid <= 1'b0;
              gap_cnt     <= gap_q;
              state       <= GAP;
            end
          end else begin
            bus.x       <= 1'b0;
            bus.x_valid <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            state       <= DONE;
          end
        end

        GAP: begin
          // gap_cnt starts at gap, so the GAP state spans exactly gap cycles.
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) begin
            bus.x       <= pat_q[W-1];
            bus.x_valid <= 1'b1;
            bit_idx     <= LAST_IDX;
            state       <= SEND;
          end
        end

        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.x       <= 1'b0;
          bus.x_valid <= 1'b0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx.
module tb_seq_pattern_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.W(4), .CNT_W(4), .GAP_W(3)) bus ();

  seq_pattern_tx #(.W(4), .CNT_W(4), .GAP_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start; returns with the first bit visible.
  task automatic start_tx(input logic [3:0] p, input logic [3:0] r, input logic [2:0] g);
    bus.pattern    = p;
    bus.repeat_cnt = r;
    bus.gap        = g;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Walks the stream from the current cycle until done (bounded by budget).
  // Cycle 0 is the current cycle; done_idx stays -1 if done never arrives.
  task automatic collect(input int budget, output logic [31:0] stream, output int nv,
                         output int done_idx, output int gap_cyc, output int det);
    logic [3:0] win;
    stream = '0; nv = 0; done_idx = -1; gap_cyc = 0; det = 0; win = '0;
    for (int i = 0; i < budget; i++) begin
      chk("inv_x_zero_when_invalid", 32'(bus.x & ~bus.x_valid), 32'd0);
      chk("inv_done_busy_exclusive", 32'(bus.done & bus.busy), 32'd0);
      if (bus.x_valid) begin
        stream = {stream[30:0], bus.x};
        nv++;
        win = {win[2:0], bus.x};
        if (nv >= 4 && win == 4'b1001) det++;
      end else if (bus.busy) begin
        gap_cyc++;
      end
      if (bus.done) begin
        done_idx = i;
        break;
      end
      tick();
    end
  endtask

  logic [31:0] stream;
  int nv, done_idx, gap_cyc, det;
  logic [17:0] vbits, exp_v;
  logic [31:0] s5;
  int nv5;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.repeat_cnt = '0; bus.gap = '0;
    tick(); tick();
    chk("reset_x", 32'(bus.x), 0);
    chk("reset_x_valid", 32'(bus.x_valid), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    reset = 1'b0;
    tick();

    // Single transmission of 1001
    start_tx(4'b1001, 4'd1, 3'd0);
    chk("t1_first_x", 32'(bus.x), 1);
    chk("t1_first_valid", 32'(bus.x_valid), 1);
    chk("t1_first_busy", 32'(bus.busy), 1);
    collect(20, stream, nv, done_idx, gap_cyc, det);
    chk("t1_stream", stream, 32'h9);
    chk("t1_nvalid", 32'(nv), 4);
    chk("t1_done_idx", 32'(done_idx), 4);
    tick();
    chk("t1_done_one_cycle", 32'(bus.done), 0);
    chk("t1_idle_busy", 32'(bus.busy), 0);

    // start pulsed mid-transmission is ignored
    start_tx(4'b1001, 4'd1, 3'd0);
    tick();
    bus.start = 1'b1; bus.pattern = 4'b0110;
    tick();
    bus.start = 1'b0;
    collect(20, stream, nv, done_idx, gap_cyc, det);
    chk("ign_tail_stream", stream, 32'h1);
    chk("ign_tail_nvalid", 32'(nv), 2);
    chk("ign_done_idx", 32'(done_idx), 2);
    tick();
    chk("ign_no_retrigger_a", 32'(bus.busy), 0);
    tick();
    chk("ign_no_retrigger_b", 32'(bus.busy), 0);

    // Reset during the second bit
    start_tx(4'b1001, 4'd1, 3'd0);
    tick();
    chk("rst_bit1_valid", 32'(bus.x_valid), 1);
    reset = 1'b1;
    #1;
    chk("rst_async_x", 32'(bus.x), 0);
    chk("rst_async_valid", 32'(bus.x_valid), 0);
    chk("rst_async_busy", 32'(bus.busy), 0);
    tick();
    chk("rst_no_done_a", 32'(bus.done), 0);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_no_done_b", 32'(bus.done), 0);
    tick();
    chk("rst_stays_idle", 32'(bus.busy), 0);

    // Back-to-back repeats
    start_tx(4'b1011, 4'd3, 3'd0);
    collect(40, stream, nv, done_idx, gap_cyc, det);
    chk("t2_stream", stream, 32'hBBB);
    chk("t2_nvalid", 32'(nv), 12);
    chk("t2_gap_cycles", 32'(gap_cyc), 0);
    chk("t2_done_idx", 32'(done_idx), 12);
    tick();

    // Gap insertion
    start_tx(4'b1001, 4'd2, 3'd2);
    collect(40, stream, nv, done_idx, gap_cyc, det);
    chk("t3_stream", stream, 32'h99);
    chk("t3_nvalid", 32'(nv), 8);
    chk("t3_gap_cycles", 32'(gap_cyc), 2);
    chk("t3_done_idx", 32'(done_idx), 10);
    chk("t3_detections", 32'(det), 2);
    tick();

    // repeat=0 acts as 1
    start_tx(4'b1010, 4'd0, 3'd0);
    collect(20, stream, nv, done_idx, gap_cyc, det);
    chk("t4a_stream", stream, 32'hA);
    chk("t4a_nvalid", 32'(nv), 4);
    chk("t4a_done_idx", 32'(done_idx), 4);
    tick();

    // Maximum gap
    start_tx(4'b1100, 4'd2, 3'd7);
    collect(40, stream, nv, done_idx, gap_cyc, det);
    chk("t4b_stream", stream, 32'hCC);
    chk("t4b_gap_cycles", 32'(gap_cyc), 7);
    chk("t4b_done_idx", 32'(done_idx), 15);
    tick();

    // All-zero pattern still produces valid cycles
    start_tx(4'b0000, 4'd1, 3'd0);
    collect(20, stream, nv, done_idx, gap_cyc, det);
    chk("t4c_stream", stream, 32'h0);
    chk("t4c_nvalid", 32'(nv), 4);
    chk("t4c_done_idx", 32'(done_idx), 4);
    tick();

    // start held high: DONE + IDLE between transmissions; pattern change hits the next one
    bus.pattern = 4'b1100; bus.repeat_cnt = 4'd1; bus.gap = 3'd0; bus.start = 1'b1;
    tick();
    vbits = '0; exp_v = '0; s5 = '0; nv5 = 0;
    for (int i = 0; i < 18; i++) begin
      vbits = {vbits[16:0], bus.x_valid};
      exp_v = {exp_v[16:0], ((i % 6) < 4) ? 1'b1 : 1'b0};
      if (bus.x_valid) begin
        s5 = {s5[30:0], bus.x};
        nv5++;
      end
      if (i == 1) bus.pattern = 4'b0110;
      if (i == 17) bus.start = 1'b0;
      tick();
    end
    chk("t5_valid_spacing", 32'(vbits), 32'(exp_v));
    chk("t5_stream", s5, 32'hC66);
    chk("t5_nvalid", 32'(nv5), 12);
    chk("t5_stops_busy", 32'(bus.busy), 0);
    chk("t5_stops_valid", 32'(bus.x_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
